spi_miso_transmitter: RTL

// - SPI slave transmit side (MISO) for the sprite-command link. Returns status and response bytes to the MCU.
// - Each CS frame first shifts out a latched 8-bit status byte, then bytes popped from an internal TX FIFO.
// - Sends IDLE_BYTE whenever the FIFO is empty.
// - Runs entirely in the FPGA clock domain; SPI clock and CS are oversampled. Sits beside spi_reader in spi_driver.

---
 rtl/spi_miso_transmitter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_miso_transmitter.sv
// rtl/spi_miso_transmitter.sv - SPI slave MISO transmitter: status byte then TX FIFO bytes per CS frame
//
// Purpose
//   Transmit side of the SPI slave on the sprite-command link. At each chip-select
//   assertion the current status word is latched and shifted out MSB first. It is
//   followed by bytes popped from an internal TX FIFO, or IDLE_BYTE when the FIFO
//   is empty. SCK and CS are oversampled in the FPGA clock domain. The clock must
//   run at least 4x faster than SCK.
//
// Ports
//   clock_i        FPGA clock, all logic on posedge
//   reset_i        asynchronous, active-high reset
//   spi_clk_i      SPI SCK from the master, mode 0
//   spi_cs_i       SPI chip select, active low
//   spi_miso_o     serial data to the master, MSB first
//   spi_miso_oe_o  MISO output enable, high while selected
//   status_i       status word, latched when CS assertion is detected
//   tx_data_i      response byte to enqueue
//   tx_valid_i     tx_data_i valid
//   tx_ready_o     FIFO can accept a byte
//   fifo_level_o   current FIFO occupancy
//   byte_sent_o    one-cycle pulse when a full byte has been shifted out
//   underflow_o    one-cycle pulse when IDLE_BYTE is loaded because the FIFO is empty

module spi_miso_transmitter #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                spi_clk_i,
    input  logic                                spi_cs_i,
    output logic                                spi_miso_o,
    output logic                                spi_miso_oe_o,
    input  logic [7:0]                          status_i,
    input  logic [7:0]                          tx_data_i,
    input  logic                                tx_valid_i,
    output logic                                tx_ready_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o,
    output logic                                byte_sent_o,
    output logic                                underflow_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;
    logic                   sck_s;
    logic                   cs_s;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    // CS resets to the deselected level so that reset release never fakes a
    // CS falling edge while the master is idle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_fall = sck_prev_q & ~sck_s;
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             shreg_q;
    logic [7:0]             shreg_d;
    logic [2:0]             bit_cnt_q;
    logic [2:0]             bit_cnt_d;
    logic                   byte_sent_q;
    logic                   byte_sent_d;
    logic                   underflow_q;
    logic                   underflow_d;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_d;
    logic [LVL_W-1:0]       level_q;
    logic [LVL_W-1:0]       level_d;

    logic                   fifo_empty;
    logic                   byte_end;
    logic                   push;
    logic                   pop;

    // The last bit of a byte leaves on this falling edge. A CS rise in the
    // same cycle wins, so nothing is popped for a frame that is ending.
    assign byte_end   = (state_q == ST_SHIFT) && !cs_rise && sck_fall && (bit_cnt_q == 3'd0);
    assign fifo_empty = (level_q == '0);
    assign pop        = byte_end && !fifo_empty;
    assign tx_ready_o = (level_q != LVL_FULL);
    assign push       = tx_valid_i && tx_ready_o;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        spi_miso_o    = 1'b0;
        spi_miso_oe_o = 1'b0;
        if (state_q == ST_SHIFT) begin
            spi_miso_o    = shreg_q[7];
            spi_miso_oe_o = 1'b1;
        end
    end

    assign byte_sent_o  = byte_sent_q;
    assign underflow_o  = underflow_q;
    assign fifo_level_o = level_q;

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    // Data changes only on SCK falling edges so that it is stable when the
    // mode-0 master samples on the rising edge. A byte cut short by CS rising
    // is simply abandoned; its FIFO entry was already consumed at load time.
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_sent_d = 1'b0;
        underflow_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                shreg_d   = status_i;
                bit_cnt_d = 3'd7;
            end
        end else if (!cs_rise && sck_fall) begin
            if (bit_cnt_q != 3'd0) begin
                shreg_d   = {shreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 3'd1;
            end else begin
                byte_sent_d = 1'b1;
                bit_cnt_d   = 3'd7;
                if (fifo_empty) begin
                    shreg_d     = IDLE_BYTE;
                    underflow_d = 1'b1;
                end else begin
                    shreg_d = mem_q[rd_ptr_q];
                end
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            byte_sent_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_sent_q <= byte_sent_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // Pointers wrap naturally because the depth is a power of two. A push and
    // a pop together leave the level unchanged; a push into a full FIFO is
    // already blocked by tx_ready_o, even if a pop frees a slot that cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data_i;
        end
    end

endmodule
